pc_target_table: RTL

//  Runtime-programmable jump-target table for the fetch stage. A 4-bit immediate
//  (generally INDEX_WIDTH bits) selects a full PC target. This replaces a fixed

---
 rtl/pc_lut_pkg.sv | 12 +
 rtl/pc_lut_mem.sv | 36 +++
 rtl/pc_target_table.sv | 112 +++++++++++
 3 files changed

// File: rtl/pc_lut_pkg.sv
// rtl/pc_lut_pkg.sv - shared widths and FSM state type for the PC target table
package pc_lut_pkg;

  localparam int PC_WIDTH_DEF    = 12;
  localparam int INDEX_WIDTH_DEF = 4;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } pc_lut_state_t;

endpackage

// File: rtl/pc_lut_mem.sv
// rtl/pc_lut_mem.sv - target PC storage with valid bits, one write port, one clear port
module pc_lut_mem #(
  parameter int PC_WIDTH    = 12,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   clr_en,
  input  logic [INDEX_WIDTH-1:0] clr_index,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [PC_WIDTH-1:0]    wr_pc,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic                   rd_valid,
  output logic [PC_WIDTH-1:0]    rd_pc
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;

  logic [PC_WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0]    valid;

  // Contents are defined only by the clear sequence, so no reset on the array.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid[clr_index] <= 1'b0;
      data[clr_index]  <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
      data[wr_index]  <= wr_pc;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_pc    = data[rd_index];

endmodule

// File: rtl/pc_target_table.sv
// rtl/pc_target_table.sv - programmable jump-target table with clear FSM and registered lookup
module pc_target_table
  import pc_lut_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  output logic                   busy,
  input  logic                   wr_en,
  output logic                   wr_ready,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [PC_WIDTH-1:0]    wr_pc,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [INDEX_WIDTH-1:0] req_index,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [PC_WIDTH-1:0]    resp_pc
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(DEPTH - 1);

  pc_lut_state_t          state, state_next;
  logic [INDEX_WIDTH-1:0] clr_idx, clr_idx_next;
  logic                   clr_en;
  logic                   wr_accept, req_accept, fwd;
  logic                   rd_valid;
  logic [PC_WIDTH-1:0]    rd_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    case (state)
      INIT: begin
        if (flush) begin
          clr_idx_next = '0;
        end else if (clr_idx == LAST_IDX) begin
          state_next   = READY;
          clr_idx_next = '0;
        end else begin
          clr_idx_next = clr_idx + INDEX_WIDTH'(1);
        end
      end
      READY: begin
        if (flush) begin
          state_next   = INIT;
          clr_idx_next = '0;
        end
      end
      default: begin
        state_next   = INIT;
        clr_idx_next = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state == INIT);
    clr_en    = (state == INIT);
    wr_ready  = !busy;
    req_ready = !busy;
  end

  // Flush wins over a same-cycle write; a write under reset is never committed.
  assign wr_accept  = wr_en && wr_ready && !flush && !reset;
  assign req_accept = req_valid && req_ready;
  assign fwd        = wr_accept && (wr_index == req_index);

  pc_lut_mem #(
    .PC_WIDTH   (PC_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_mem (
    .clk      (clk),
    .clr_en   (clr_en),
    .clr_index(clr_idx),
    .wr_en    (wr_accept),
    .wr_index (wr_index),
    .wr_pc    (wr_pc),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_pc    (rd_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_pc    <= '0;
    end else begin
      resp_valid <= req_accept;
      if (req_accept) begin
        resp_hit <= fwd || rd_valid;
        resp_pc  <= fwd ? wr_pc : (rd_valid ? rd_pc : '0);
      end
    end
  end

endmodule
